// File: rtl/line_draw_arbiter.sv
// Two-port round-robin arbiter in front of a single line_drawer: captures the
// winning command, runs the drawer's start/done handshake and guards it with a watchdog.
//
// Handshakes: req[i] is a valid held with a stable cmd until gnt[i] pulses (the
// capture acknowledge); start is the drawer's valid, held until done is seen,
// after which done must fall again before the next command can be captured.
module line_draw_arbiter #(
  parameter int X_W            = 8,
  parameter int Y_W            = 7,
  parameter int COL_W          = 3,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [1:0]                     req,
  input  logic [2*X_W+2*Y_W+COL_W-1:0]   cmd0,
  input  logic [2*X_W+2*Y_W+COL_W-1:0]   cmd1,
  output logic [1:0]                     gnt,
  output logic [1:0]                     cmpl,
  output logic                           cmpl_err,
  output logic                           timeout_err,
  output logic                           busy,
  output logic                           start,
  output logic [X_W-1:0]                 x0,
  output logic [Y_W-1:0]                 y0,
  output logic [X_W-1:0]                 x1,
  output logic [Y_W-1:0]                 y1,
  output logic [COL_W-1:0]               colour,
  input  logic                           done,
  output logic [1:0]                     dbg_state
);

  localparam int CMD_W = 2*X_W + 2*Y_W + COL_W;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DRAW    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]       r_state;
  logic             r_owner;
  logic             r_last;
  logic [WD_W-1:0]  r_wd;
  logic [1:0]       r_gnt;
  logic [1:0]       r_cmpl;
  logic             r_cmpl_err;
  logic             r_timeout_err;
  logic             r_busy;
  logic             r_start;
  logic [CMD_W-1:0] r_cmd;

  logic             w_win;
  logic [CMD_W-1:0] w_cmd;

  // A tie goes to whichever requester did not own the previous draw.
  always_comb begin
    w_win = 1'b0;
    case (req)
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last;
      default: w_win = 1'b0;
    endcase
    w_cmd = w_win ? cmd1 : cmd0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_last        <= 1'b1;
      r_wd          <= '0;
      r_gnt         <= '0;
      r_cmpl        <= '0;
      r_cmpl_err    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
      r_start       <= 1'b0;
      r_cmd         <= '0;
    end else begin
      r_gnt      <= '0;
      r_cmpl     <= '0;
      r_cmpl_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req != 2'b00) begin
            r_state <= S_DRAW;
            r_cmd   <= w_cmd;
            r_owner <= w_win;
            r_last  <= w_win;
            r_wd    <= '0;
            r_gnt   <= w_win ? 2'b10 : 2'b01;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_DRAW: begin
          // done takes priority over the watchdog limit in the same cycle.
          if (done) begin
            r_state <= S_RELEASE;
            r_start <= 1'b0;
            r_cmpl  <= r_owner ? 2'b10 : 2'b01;
          end else if (r_wd == WD_LAST) begin
            r_state       <= S_RELEASE;
            r_start       <= 1'b0;
            r_cmpl        <= r_owner ? 2'b10 : 2'b01;
            r_cmpl_err    <= 1'b1;
            r_timeout_err <= 1'b1;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        S_RELEASE: begin
          // Wait out a lingering done so it cannot complete the next draw.
          if (!done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_start <= 1'b0;
        end
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign cmpl        = r_cmpl;
  assign cmpl_err    = r_cmpl_err;
  assign timeout_err = r_timeout_err;
  assign busy        = r_busy;
  assign start       = r_start;
  assign {x0, y0, x1, y1, colour} = r_cmd;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_line_draw_arbiter.sv
// Bench for line_draw_arbiter: three instances (long, 16- and 8-cycle watchdog)
// share stimulus; a transaction-level model predicts grants and completions.
module tb_line_draw_arbiter;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;
  localparam int CMD_W = 2*X_W + 2*Y_W + COL_W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       req;
  logic [CMD_W-1:0] cmd0, cmd1;
  logic             done;

  logic [1:0]       gnt_a   [0:2];
  logic [1:0]       cmpl_a  [0:2];
  logic             cerr_a  [0:2];
  logic             terr_a  [0:2];
  logic             busy_a  [0:2];
  logic             start_a [0:2];
  logic [X_W-1:0]   x0_a    [0:2];
  logic [Y_W-1:0]   y0_a    [0:2];
  logic [X_W-1:0]   x1_a    [0:2];
  logic [Y_W-1:0]   y1_a    [0:2];
  logic [COL_W-1:0] col_a   [0:2];
  logic [1:0]       dbg_a   [0:2];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    line_draw_arbiter #(
      .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W),
      .TIMEOUT_CYCLES(g == 0 ? 64 : (g == 1 ? 16 : 8))
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .req(req), .cmd0(cmd0), .cmd1(cmd1),
      .gnt(gnt_a[g]), .cmpl(cmpl_a[g]), .cmpl_err(cerr_a[g]),
      .timeout_err(terr_a[g]), .busy(busy_a[g]), .start(start_a[g]),
      .x0(x0_a[g]), .y0(y0_a[g]), .x1(x1_a[g]), .y1(y1_a[g]),
      .colour(col_a[g]), .done(done), .dbg_state(dbg_a[g])
    );
  end

  // Observed instance is selected by sel; T_cur is its watchdog limit.
  logic [1:0]       sel;
  int               t_cur;
  logic [1:0]       gnt_o, cmpl_o;
  logic             cerr_o, terr_o, busy_o, start_o;
  logic [CMD_W-1:0] obs_cmd;

  always_comb begin
    gnt_o   = gnt_a[sel];
    cmpl_o  = cmpl_a[sel];
    cerr_o  = cerr_a[sel];
    terr_o  = terr_a[sel];
    busy_o  = busy_a[sel];
    start_o = start_a[sel];
    obs_cmd = {x0_a[sel], y0_a[sel], x1_a[sel], y1_a[sel], col_a[sel]};
  end

  // ---------------- scoreboard / model state ----------------
  int               n_checks;
  int               n_pass;
  logic [1:0]       exp_q[$];
  logic [1:0]       pend;
  logic [CMD_W-1:0] pcmd [0:1];
  logic             last_owner;
  logic             tmo_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CMD_W-1:0] rnd_cmd();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[CMD_W-1:0];
  endfunction

  task automatic raise(input int i, input logic [CMD_W-1:0] c);
    pend[i] = 1'b1;
    pcmd[i] = c;
    if (i == 0) cmd0 = c;
    else        cmd1 = c;
    req = pend;
  endtask

  task automatic inject();
    for (int i = 0; i < 2; i++)
      if (!pend[i] && $urandom_range(0, 7) == 0) raise(i, rnd_cmd());
  endtask

  function automatic logic pick();
    if (pend == 2'b01)      return 1'b0;
    else if (pend == 2'b10) return 1'b1;
    else                    return ~last_owner;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    pend = 2'b00;
    req = 2'b00;
    done = 1'b0;
    cmd0 = rnd_cmd();
    cmd1 = rnd_cmd();
    step();
    step();
    check("rst_gnt", gnt_o, 0);
    check("rst_cmpl", cmpl_o, 0);
    check("rst_cerr", cerr_o, 0);
    check("rst_terr", terr_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_start", start_o, 0);
    check("rst_cmd", obs_cmd, 0);
    last_owner = 1'b1;
    tmo_seen = 1'b0;
    exp_q.delete();
    reset_n = 1'b1;
    step();
    check("post_rst_busy", busy_o, 0);
  endtask

  // Precondition: DUT idle and pend != 0 already driven. d = DRAW cycles before
  // done is raised, s = extra cycles done is held in RELEASE.
  task automatic do_draw(input int d, input int s, input bit rerise, input bit inj);
    logic             w;
    logic [CMD_W-1:0] ec;
    logic [1:0]       e;
    bit               err;
    bit               exit_now;
    w = pick();
    step();
    last_owner = w;
    ec = pcmd[w];
    check("gnt", gnt_o, w ? 2'b10 : 2'b01);
    check("start_on", start_o, 1);
    check("busy_draw", busy_o, 1);
    check("cmd_out", obs_cmd, ec);
    check("cmpl_at_gnt", cmpl_o, 0);
    exp_q.push_back(w ? 2'b10 : 2'b01);
    pend[w] = 1'b0;
    req = pend;
    if (rerise) raise(w, rnd_cmd());
    err = 1'b0;
    for (int k = 0; k < t_cur; k++) begin
      done = (k >= d);
      if (inj) inject();
      exit_now = (k >= d) || (k == t_cur - 1);
      err = (k < d) && (k == t_cur - 1);
      step();
      if (exit_now) break;
      check("start_hold", start_o, 1);
      check("gnt_hold", gnt_o, 0);
      check("cmpl_hold", cmpl_o, 0);
    end
    tmo_seen = tmo_seen | err;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
    check("cmpl", cmpl_o, e);
    check("cmpl_err", cerr_o, err);
    check("timeout_err", terr_o, tmo_seen);
    check("start_off", start_o, 0);
    check("cmd_frozen", obs_cmd, ec);
    for (int j = 0; j < s; j++) begin
      done = 1'b1;
      if (inj) inject();
      step();
      check("rel_busy", busy_o, 1);
      check("rel_start", start_o, 0);
      check("rel_gnt", gnt_o, 0);
      check("rel_cmpl", cmpl_o, 0);
    end
    done = 1'b0;
    step();
    check("idle_busy", busy_o, 0);
    check("idle_gnt", gnt_o, 0);
    check("idle_cmpl", cmpl_o, 0);
    check("idle_cerr", cerr_o, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [CMD_W-1:0] c;
    logic             w;
    n_checks = 0;
    n_pass = 0;
    sel = 2'd0;
    t_cur = 64;
    reset_n = 1'b0;
    req = 2'b00;
    done = 1'b0;
    cmd0 = '0;
    cmd1 = '0;
    pend = 2'b00;
    last_owner = 1'b1;
    tmo_seen = 1'b0;

    // Single request with the reference coordinates.
    do_reset();
    c = {8'd10, 7'd5, 8'd100, 7'd90, 3'b101};
    raise(0, c);
    do_draw(39, 0, 1'b0, 1'b0);

    // Tie held on both ports: grants must alternate 0,1,0,1.
    do_reset();
    raise(0, rnd_cmd());
    raise(1, rnd_cmd());
    for (int i = 0; i < 4; i++) begin
      check("rr_pick", pick(), i % 2);
      do_draw(9, 0, 1'b1, 1'b0);
    end
    pend = 2'b00;
    req = 2'b00;
    step();

    // Sticky done with a pending request.
    raise(0, rnd_cmd());
    do_draw(5, 5, 1'b1, 1'b0);
    do_draw(3, 0, 1'b0, 1'b0);

    // Reset in the middle of a draw with both requests held.
    raise(0, rnd_cmd());
    raise(1, rnd_cmd());
    w = pick();
    step();
    check("mid_gnt", gnt_o, w ? 2'b10 : 2'b01);
    step();
    step();
    reset_n = 1'b0;
    step();
    check("mid_rst_start", start_o, 0);
    check("mid_rst_gnt", gnt_o, 0);
    check("mid_rst_cmpl", cmpl_o, 0);
    check("mid_rst_cmd", obs_cmd, 0);
    check("mid_rst_terr", terr_o, 0);
    check("mid_rst_busy", busy_o, 0);
    last_owner = 1'b1;
    tmo_seen = 1'b0;
    exp_q.delete();
    reset_n = 1'b1;
    check("mid_rst_first", pick(), 0);
    do_draw(4, 0, 1'b0, 1'b0);
    do_draw(2, 0, 1'b0, 1'b0);

    // Randomised traffic, including some watchdog expiries.
    for (int n = 0; n < 40; n++) begin
      if (pend == 2'b00) begin
        repeat ($urandom_range(0, 3)) begin
          step();
          check("rand_idle_busy", busy_o, 0);
          check("rand_idle_gnt", gnt_o, 0);
        end
        raise($urandom_range(0, 1), rnd_cmd());
      end
      do_draw($urandom_range(0, 70), $urandom_range(0, 3), 1'b0, 1'b1);
    end

    // Timeout on the 16-cycle instance, then a clean draw.
    sel = 2'd1;
    t_cur = 16;
    do_reset();
    raise(1, rnd_cmd());
    do_draw(100, 0, 1'b0, 1'b0);
    raise(0, rnd_cmd());
    do_draw(3, 0, 1'b0, 1'b0);

    // done lands on the 8-cycle watchdog's final cycle: done wins.
    sel = 2'd2;
    t_cur = 8;
    do_reset();
    raise(0, rnd_cmd());
    do_draw(7, 0, 1'b0, 1'b0);
    check("collide_terr", terr_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
